// File: rtl/itcm_arb_if.sv
// Bus bundle between the two ITCM requesters (IF/EX), the arbiter and the single-port RAM.
// The master modport is the requester/RAM side; the slave modport is the arbiter.
interface itcm_arb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    if_req_i;
  logic [ADDR_WIDTH-1:0]   if_addr_i;
  logic                    if_gnt_o;
  logic                    if_rvalid_o;
  logic [DATA_WIDTH-1:0]   if_rdata_o;

  logic                    ex_req_i;
  logic                    ex_we_i;
  logic [ADDR_WIDTH-1:0]   ex_addr_i;
  logic [DATA_WIDTH-1:0]   ex_wdata_i;
  logic [DATA_WIDTH/8-1:0] ex_wmask_i;
  logic                    ex_gnt_o;
  logic                    ex_rvalid_o;
  logic [DATA_WIDTH-1:0]   ex_rdata_o;

  logic                    ram_ce_o;
  logic                    ram_we_o;
  logic [DATA_WIDTH/8-1:0] ram_wmask_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic [DATA_WIDTH-1:0]   ram_wdata_o;
  logic [DATA_WIDTH-1:0]   ram_rdata_i;

  logic                    hold_flag_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i, ex_wmask_i,
    output ex_gnt_o, ex_rvalid_o, ex_rdata_o,
    output ram_ce_o, ram_we_o, ram_wmask_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i,
    output hold_flag_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i, ex_wmask_i,
    input  ex_gnt_o, ex_rvalid_o, ex_rdata_o,
    input  ram_ce_o, ram_we_o, ram_wmask_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i,
    input  hold_flag_o
  );
endinterface

// File: rtl/itcm_arb.sv
// ITCM arbiter: combinational EX-over-IF grant onto a 1-cycle-latency single-port RAM.
// Define ITCM_ARB_STARVE_EN to build the IF starvation guard (STARVE_LIMIT EX grants max).
module itcm_arb #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic        clk,
  input logic        rst,
  itcm_arb_if.slave  bus
);
  localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {StNone, StIfRd, StExRd} state_e;

  state_e                  state_q;
  logic                    if_rvalid_q;
  logic                    ex_rvalid_q;
  logic                    force_if;
  logic                    if_gnt;
  logic                    ex_gnt;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [DATA_WIDTH/8-1:0] wmask_sel;

`ifdef ITCM_ARB_STARVE_EN
  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starve_cnt_q;

  assign force_if = bus.if_req_i && (starve_cnt_q == CntW'(STARVE_LIMIT));

  // Counts EX wins while IF is waiting; the forced IF grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (if_gnt || !bus.if_req_i) begin
      starve_cnt_q <= '0;
    end else if (ex_gnt) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_gnt    = bus.if_req_i && (!bus.ex_req_i || force_if);
    ex_gnt    = bus.ex_req_i && !force_if;
    addr_sel  = ex_gnt ? bus.ex_addr_i : bus.if_addr_i;
    wmask_sel = (ex_gnt && bus.ex_we_i) ? bus.ex_wmask_i : '0;
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ex_gnt_o    = ex_gnt;
  assign bus.hold_flag_o = bus.if_req_i && !if_gnt;

  assign bus.ram_ce_o    = if_gnt || ex_gnt;
  assign bus.ram_we_o    = ex_gnt && bus.ex_we_i;
  assign bus.ram_wmask_o = wmask_sel;
  assign bus.ram_addr_o  = addr_sel;
  assign bus.ram_wdata_o = bus.ex_wdata_i;

  // Return owner tracks who the RAM read data belongs to on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StNone;
      if_rvalid_q <= 1'b0;
      ex_rvalid_q <= 1'b0;
    end else if (if_gnt) begin
      state_q     <= StIfRd;
      if_rvalid_q <= 1'b1;
      ex_rvalid_q <= 1'b0;
    end else if (ex_gnt && !bus.ex_we_i) begin
      state_q     <= StExRd;
      if_rvalid_q <= 1'b0;
      ex_rvalid_q <= 1'b1;
    end else begin
      state_q     <= StNone;
      if_rvalid_q <= 1'b0;
      ex_rvalid_q <= 1'b0;
    end
  end

  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.ex_rvalid_o = ex_rvalid_q;
  assign bus.if_rdata_o  = (state_q == StIfRd) ? bus.ram_rdata_i : Nop;
  assign bus.ex_rdata_o  = (state_q == StExRd) ? bus.ram_rdata_i : '0;

endmodule
